// File: rtl/outport_uart_tx_if.sv
// outport_uart_tx_if: processor output port sample plus UART line and queue status.
interface outport_uart_tx_if;
    logic [7:0] portData;
    logic       tx;
    logic       txBusy;
    logic       fifoEmpty;
    logic       fifoFull;
    logic       overflow;
    modport master (output portData, input tx, txBusy, fifoEmpty, fifoFull, overflow);
    modport slave  (input portData, output tx, txBusy, fifoEmpty, fifoFull, overflow);
endinterface

// File: rtl/outport_uart_tx.sv
// outport_uart_tx: queues every change of the processor outPort and streams it as 8N1 UART frames.
module outport_uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk,
    input logic             reset,
    outport_uart_tx_if.slave port
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    last_q, last_d, shift_q, shift_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    state_t        state_q, state_d;
    logic          tx_q, tx_d, busy_q, busy_d, empty_q, empty_d, full_q, full_d, overflow_q, overflow_d;
    logic          push, pop, push_ok, bit_end;
    always_comb begin
        last_d     = port.portData;
        push       = port.portData != last_q;
        pop        = state_q == IDLE && count_q != '0;
        // a pop on the same edge frees the slot the push needs
        push_ok    = push && (count_q < CW'(FIFO_DEPTH) || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q | (push & ~push_ok);
        empty_d    = count_d == '0;
        full_d     = count_d == CW'(FIFO_DEPTH);
        bit_end    = baud_q == BW'(DIV - 1);
        state_d    = state_q;
        baud_d     = bit_end ? '0 : baud_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shift_q[1];
                end
            end
            default: if (bit_end) begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= port.portData;
            last_q     <= last_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end
    assign port.tx        = tx_q;
    assign port.txBusy    = busy_q;
    assign port.fifoEmpty = empty_q;
    assign port.fifoFull  = full_q;
    assign port.overflow  = overflow_q;
endmodule

// File: tb/tb_outport_uart_tx.sv
// tb_outport_uart_tx: directed checks of change detect, queueing, overflow and 8N1 framing (DIV=10, depth 4).
module tb_outport_uart_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   cmp = 0;
    int   bad = 0;
    outport_uart_tx_if b ();
    outport_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .port(b.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_start(input string tag, output int t);
        int n = 0;
        while (b.tx !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, " start"}, b.tx, 0);
        t = cyc;
    endtask
    // walks a frame from sample index skip (0 = the cycle tx fell) through the idle cycle after stop
    task automatic frame(input string tag, input logic [7:0] d, input int skip);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int k = skip; k < 100; k++) begin
            if (k % 10 == 0 || k % 10 == 9) begin
                chk($sformatf("%s bit%0d", tag, k / 10), b.tx, bits[k / 10]);
                chk($sformatf("%s busy%0d", tag, k), b.txBusy, 1);
            end
            tick();
        end
        chk({tag, " end busy"}, b.txBusy, 0);
        chk({tag, " end tx"}, b.tx, 1);
    endtask
    initial begin
        int t0, t1, lows, skip;
        logic full_seen;
        b.portData = 8'h00;
        tick();
        tick();
        chk("rst tx", b.tx, 1);
        chk("rst busy", b.txBusy, 0);
        chk("rst empty", b.fifoEmpty, 1);
        chk("rst full", b.fifoFull, 0);
        chk("rst ovf", b.overflow, 0);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            lows += (b.tx !== 1'b1 || b.txBusy !== 1'b0 || b.fifoEmpty !== 1'b1) ? 1 : 0;
        end
        chk("zero hold quiet", lows, 0);
        b.portData = 8'h37;
        t0 = cyc;
        wait_start("f37", t1);
        chk("f37 latency", t1 - t0, 2);
        frame("f37", 8'h37, 0);
        b.portData = 8'h01;
        tick();
        b.portData = 8'h03;
        tick();
        b.portData = 8'h06;
        wait_start("f01", t0);
        frame("f01", 8'h01, 0);
        wait_start("f03", t1);
        chk("space 01-03", t1 - t0, 101);
        frame("f03", 8'h03, 0);
        wait_start("f06", t0);
        chk("space 03-06", t0 - t1, 101);
        frame("f06", 8'h06, 0);
        chk("ovf after 3", b.overflow, 0);
        full_seen = 1'b0;
        t1 = -1;
        for (int k = 0; k < 6; k++) begin
            b.portData = 8'h11 + 8'(k);
            tick();
            full_seen |= b.fifoFull;
            if (t1 < 0 && b.tx === 1'b0) t1 = cyc;
        end
        chk("full seen", full_seen, 1);
        chk("ovf set", b.overflow, 1);
        skip = cyc - t1;
        chk("f11 offset", skip, 4);
        frame("f11", 8'h11, 4);
        for (int k = 2; k < 6; k++) begin
            wait_start($sformatf("f1%0d", k), t0);
            frame($sformatf("f1%0d", k), 8'h10 + 8'(k), 0);
        end
        chk("ovf sticky", b.overflow, 1);
        chk("empty after burst", b.fifoEmpty, 1);
        b.portData = 8'h2A;
        wait_start("f2A", t0);
        frame("f2A", 8'h2A, 0);
        lows = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            lows += (b.tx !== 1'b1) ? 1 : 0;
        end
        chk("hold 2A one frame", lows, 0);
        b.portData = 8'h55;
        tick();
        b.portData = 8'hAA;
        tick();
        chk("f55a start", b.tx, 0);
        b.portData = 8'hBB;
        tick();
        for (int i = 0; i < 53; i++) tick();
        chk("pre-rst busy", b.txBusy, 1);
        chk("pre-rst empty", b.fifoEmpty, 0);
        chk("pre-rst bit4", b.tx, 1);
        reset = 1'b1;
        b.portData = 8'h00;
        tick();
        reset = 1'b0;
        chk("abort tx", b.tx, 1);
        chk("abort busy", b.txBusy, 0);
        chk("abort empty", b.fifoEmpty, 1);
        chk("abort ovf", b.overflow, 0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            lows += (b.tx !== 1'b1) ? 1 : 0;
        end
        chk("no frame after abort", lows, 0);
        b.portData = 8'h55;
        t0 = cyc;
        wait_start("f55b", t1);
        chk("f55b latency", t1 - t0, 2);
        frame("f55b", 8'h55, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
